// File: rtl/pc_alu_datapath_pkg.sv
// Shared ALU operation codes and result-select encodings for the execute slice.
package pc_alu_datapath_pkg;

    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned ALU_SEL_W  = 2;

    // Full operation codes driven by the core's ALU decoder
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_ANDN = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_ORN  = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 3'b111;

    // Result select field (low two bits of the op code)
    localparam logic [ALU_SEL_W-1:0] SEL_AND = 2'b00;
    localparam logic [ALU_SEL_W-1:0] SEL_OR  = 2'b01;
    localparam logic [ALU_SEL_W-1:0] SEL_SUM = 2'b10;
    localparam logic [ALU_SEL_W-1:0] SEL_SLT = 2'b11;

endpackage

// File: rtl/pc_alu_datapath_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with optional operand-B inversion.
// Standalone so the branch comparator can reuse it directly.
module alu
    import pc_alu_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [ALU_CTRL_W-1:0] f,
    output logic                  cout,
    output logic                  zero,
    output logic [WIDTH-1:0]      y
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] bb;
    logic [SUM_W-1:0] sum;

    // Shared adder; f[2] turns it into a - b via invert-and-carry-in
    always_comb begin
        bb  = f[2] ? ~b : b;
        sum = SUM_W'(a) + SUM_W'(bb) + SUM_W'(f[2]);
    end

    // Result select, carry-out and zero flag; SLT takes the raw sign of the sum
    always_comb begin
        y = '0;
        unique case (f[ALU_SEL_W-1:0])
            SEL_AND: y = a & bb;
            SEL_OR:  y = a | bb;
            SEL_SUM: y = sum[WIDTH-1:0];
            SEL_SLT: y = WIDTH'(sum[WIDTH-1]);
            default: y = '0;
        endcase
        cout = sum[WIDTH];
        zero = (y == '0);
    end

endmodule

// File: rtl/pc_alu_datapath_flopr.sv
// Enable-gated register with asynchronous active-low reset to a fixed value.
module flopr #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d on enabled edges; reset overrides the clock asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_alu_datapath_mux2.sv
// Two-input WIDTH-bit multiplexer.
module mux2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // Select d1 when s is high
    always_comb begin
        y = s ? d1 : d0;
    end

endmodule

// File: rtl/pc_alu_datapath.sv
// Execute-stage slice: PC register, ALU operand-B mux and the ALU.
module pc_alu_datapath
    import pc_alu_datapath_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_en,
    input  logic [WIDTH-1:0]      pc_next,
    output logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      reg_b,
    input  logic [WIDTH-1:0]      imm,
    input  logic                  alu_src,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]      result,
    output logic                  cout,
    output logic                  zero
);

    logic [WIDTH-1:0] src_b;

    // Program counter; held while stalled or halted
    flopr #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc)
    );

    // Operand B: register data or sign-extended immediate
    mux2 #(
        .WIDTH (WIDTH)
    ) u_src_b_mux (
        .d0 (reg_b),
        .d1 (imm),
        .s  (alu_src),
        .y  (src_b)
    );

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (src_a),
        .b    (src_b),
        .f    (alu_ctrl),
        .cout (cout),
        .zero (zero),
        .y    (result)
    );

endmodule

// File: tb/tb_pc_alu_datapath.sv
// Self-checking bench for pc_alu_datapath: ALU vector table, random vectors and PC sequences.
module tb_pc_alu_datapath;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] rb;
        logic [W-1:0] im;
        logic         src;
        logic [2:0]   ctrl;
        logic [W-1:0] y;
        logic         c;
        logic         z;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] y;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         pc_en;
    logic [W-1:0] pc_next;
    logic [W-1:0] pc;
    logic [W-1:0] src_a;
    logic [W-1:0] reg_b;
    logic [W-1:0] imm;
    logic         alu_src;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    int total = 0;
    int bad   = 0;

    exp_t sb_q[$];
    vec_t vecs[$];

    pc_alu_datapath #(
        .WIDTH    (W),
        .RESET_PC ('0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_en    (pc_en),
        .pc_next  (pc_next),
        .pc       (pc),
        .src_a    (src_a),
        .reg_b    (reg_b),
        .imm      (imm),
        .alu_src  (alu_src),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .cout     (cout),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU built from plain arithmetic and unsigned compare
    function automatic exp_t model(input string name, input logic [W-1:0] a, input logic [W-1:0] rb,
                                   input logic [W-1:0] im, input logic src, input logic [2:0] ctrl);
        exp_t         e;
        logic [W-1:0] b;
        logic [W:0]   add_w;
        logic [W-1:0] diff;
        b     = src ? im : rb;
        add_w = {1'b0, a} + {1'b0, b};
        diff  = a - b;
        e.name = name;
        e.y    = '0;
        e.c    = add_w[W];
        if (ctrl[2]) e.c = (a >= b);
        case (ctrl)
            3'b000: e.y = a & b;
            3'b001: e.y = a | b;
            3'b010: e.y = add_w[W-1:0];
            3'b011: e.y = {31'd0, add_w[W-1]};
            3'b100: e.y = a & ~b;
            3'b101: e.y = a | ~b;
            3'b110: e.y = diff;
            default: e.y = {31'd0, diff[W-1]};
        endcase
        e.z = (e.y == '0);
        return e;
    endfunction

    // Drive one ALU vector, queue its expectation, then pop and compare after settling
    task automatic apply(input string name, input logic [W-1:0] a, input logic [W-1:0] rb,
                         input logic [W-1:0] im, input logic src, input logic [2:0] ctrl,
                         input logic [W-1:0] ey, input logic ec, input logic ez);
        exp_t e;
        src_a    = a;
        reg_b    = rb;
        imm      = im;
        alu_src  = src;
        alu_ctrl = ctrl;
        e.name = name; e.y = ey; e.c = ec; e.z = ez;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check({e.name, ".result"}, result, e.y);
        check({e.name, ".cout"}, W'(cout), W'(e.c));
        check({e.name, ".zero"}, W'(zero), W'(e.z));
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] rb, input logic [W-1:0] im,
                                input logic src, input logic [2:0] ctrl,
                                input logic [W-1:0] y, input logic c, input logic z);
        vec_t v;
        v.a = a; v.rb = rb; v.im = im; v.src = src; v.ctrl = ctrl;
        v.y = y; v.c = c; v.z = z;
        return v;
    endfunction

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb, ri;
        logic [2:0]   rc;
        logic         rs;

        vecs.push_back(mk(32'd5, 32'd7, 32'hFFFF_FFFC, 1'b0, 3'b010, 32'd12, 1'b0, 1'b0));
        vecs.push_back(mk(32'd5, 32'd7, 32'hFFFF_FFFC, 1'b1, 3'b010, 32'd1, 1'b1, 1'b0));
        vecs.push_back(mk(32'h1234, 32'h1234, 32'd0, 1'b0, 3'b110, 32'd0, 1'b1, 1'b1));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 3'b000, 32'h00F0_00F0, 1'b1, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 3'b001, 32'hFFF0_FFF0, 1'b1, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 3'b100, 32'hF000_F000, 1'b1, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 3'b101, 32'hF0FF_F0FF, 1'b1, 1'b0));
        vecs.push_back(mk(32'd3, 32'd5, 32'd0, 1'b0, 3'b111, 32'd1, 1'b0, 1'b0));
        vecs.push_back(mk(32'd5, 32'd3, 32'd0, 1'b0, 3'b111, 32'd0, 1'b1, 1'b1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 3'b111, 32'd1, 1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'd1, 32'd0, 1'b0, 3'b111, 32'd0, 1'b1, 1'b1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b010, 32'd0, 1'b1, 1'b1));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b011, 32'd1, 1'b0, 1'b0));
        vecs.push_back(mk(32'd10, 32'd99, 32'd3, 1'b1, 3'b110, 32'd7, 1'b1, 1'b0));

        reset    = 1'b0;
        pc_en    = 1'b1;
        pc_next  = 32'h0000_0040;
        src_a    = '0;
        reg_b    = '0;
        imm      = '0;
        alu_src  = 1'b0;
        alu_ctrl = 3'b000;

        // Asynchronous reset before any clock edge
        #1;
        check("pc_async_reset", pc, 32'h0);

        // Reset held across an enabled edge keeps RESET_PC
        @(posedge clk); #1;
        check("pc_held_in_reset", pc, 32'h0);

        // Release mid-cycle; first enabled edge loads pc_next
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("pc_load_40", pc, 32'h40);

        pc_en   = 1'b0;
        pc_next = 32'h44;
        @(posedge clk); #1;
        check("pc_hold_en0", pc, 32'h40);

        pc_en = 1'b1;
        @(posedge clk); #1;
        check("pc_load_44", pc, 32'h44);

        // Reset asserted mid-cycle forces pc without a clock edge
        pc_next = 32'h48;
        #2 reset = 1'b0;
        #1;
        check("pc_midrun_reset", pc, 32'h0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("pc_after_rerelease", pc, 32'h48);

        // Directed ALU vectors
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].rb, vecs[i].im, vecs[i].src,
                  vecs[i].ctrl, vecs[i].y, vecs[i].c, vecs[i].z);
        end

        // Random ALU vectors against the reference model
        for (int k = 0; k < 64; k++) begin
            ra = $urandom;
            rb = (k % 8 == 0) ? ra : $urandom;
            ri = $urandom;
            rc = 3'($urandom_range(0, 7));
            rs = 1'($urandom_range(0, 1));
            e  = model($sformatf("rnd%0d", k), ra, rb, ri, rs, rc);
            apply(e.name, ra, rb, ri, rs, rc, e.y, e.c, e.z);
        end

        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
